// File: rtl/modport_mem.sv
// modport_mem: single-port synchronous RAM, 2**ADDR_WIDTH words x DATA_WIDTH bits.
// Memory target behind the mem_to_test side of the test interface.
// Ports:
//   clk      - system clock, all state changes on rising edge
//   rst      - synchronous active-high reset; clears every word and data_out
//   read     - read strobe; data_out <= mem[addr] one clock later
//   write    - write strobe; mem[addr] <= data_in (wins over read)
//   addr     - word address
//   data_in  - write data
//   data_out - registered read data, holds between reads
module modport_mem #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  // Next-state: write has priority; a read samples pre-edge contents.
  always_comb begin
    mem_d      = mem_q;
    data_out_d = data_out_q;
    if (write) begin
      mem_d[addr] = data_in;
    end else if (read) begin
      data_out_d = mem_q[addr];
    end
  end

  // State registers; reset overrides any strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_modport_mem.sv
// tb_modport_mem: self-checking bench for modport_mem.
// Inputs are driven on the falling edge; data_out is sampled 1 time unit after
// the rising edge. Expected values are pushed to a scoreboard queue when the
// stimulus is driven and popped when the corresponding edge has occurred.
module tb_modport_mem;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  typedef struct {
    string         tag;
    logic [DW-1:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [DW-1:0] mem_m [32];
  logic [DW-1:0] dout_m;

  modport_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One clock of stimulus. When chk is set, an expectation is queued:
  // the explicit value exp, or the model's prediction when use_model is set.
  task automatic cycle(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rs, input bit chk,
                       input bit use_model, input logic [DW-1:0] exp,
                       input string tag);
    sb_entry_t e;
    sb_entry_t got_e;
    @(negedge clk);
    read    = r;
    write   = w;
    addr    = a;
    data_in = d;
    rst     = rs;
    if (rs) begin
      for (int i = 0; i < 32; i++) mem_m[i] = '0;
      dout_m = '0;
    end else if (w) begin
      mem_m[a] = d;
    end else if (r) begin
      dout_m = mem_m[a];
    end
    if (chk) begin
      e.tag = tag;
      e.exp = use_model ? dout_m : exp;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (chk) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: scoreboard empty, got %02h expected an entry", tag, data_out);
      end else begin
        got_e = sb_q.pop_front();
        check_val(got_e.tag, data_out, got_e.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b0; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    dout_m = '0;

    // Reset held two cycles, then read 0/15/31.
    cycle(0, 0, 5'd0, 8'h00, 1, 0, 0, 8'h00, "rst1");
    cycle(0, 0, 5'd0, 8'h00, 1, 1, 0, 8'h00, "rst_dout");
    cycle(1, 0, 5'd0,  8'h00, 0, 1, 0, 8'h00, "rst_rd0");
    cycle(1, 0, 5'd15, 8'h00, 0, 1, 0, 8'h00, "rst_rd15");
    cycle(1, 0, 5'd31, 8'h00, 0, 1, 0, 8'h00, "rst_rd31");

    // Fill: write then a read-idle cycle, as the driver does.
    for (int i = 0; i < 32; i++) begin
      cycle(0, 1, AW'(i), DW'(8'h40 + i), 0, 0, 0, 8'h00, "fill_w");
      cycle(0, 0, AW'(i), 8'h00, 0, 0, 0, 8'h00, "fill_idle");
    end
    for (int i = 0; i < 32; i++) begin
      cycle(1, 0, AW'(i), 8'h00, 0, 1, 0, DW'(8'h40 + i), $sformatf("fill_rd%0d", i));
    end

    // Back-to-back write/read and overwrite.
    cycle(0, 1, 5'd7, 8'h5A, 0, 1, 0, DW'(8'h5F), "b2b_w_hold");
    cycle(1, 0, 5'd7, 8'h00, 0, 1, 0, 8'h5A, "b2b_rd");
    cycle(0, 1, 5'd7, 8'h61, 0, 0, 0, 8'h00, "b2b_ow");
    cycle(1, 0, 5'd7, 8'h00, 0, 1, 0, 8'h61, "b2b_rd2");

    // Simultaneous strobes: write wins, data_out holds.
    cycle(0, 1, 5'd3,  8'h33, 0, 0, 0, 8'h00, "sim_w3");
    cycle(0, 1, 5'd17, 8'h11, 0, 0, 0, 8'h00, "sim_w17");
    cycle(1, 0, 5'd17, 8'h00, 0, 1, 0, 8'h11, "sim_rd17");
    cycle(1, 1, 5'd3,  8'h44, 0, 1, 0, 8'h11, "sim_both");
    cycle(1, 0, 5'd3,  8'h00, 0, 1, 0, 8'h44, "sim_rd3");

    // Hold across idle cycles with changing address.
    cycle(1, 0, 5'd9, 8'h00, 0, 1, 0, 8'h49, "hold_rd9");
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, AW'(i * 6 + 1), DW'(i), 0, 1, 0, 8'h49, $sformatf("hold%0d", i));
    end

    // Reset in the same cycle as a write.
    cycle(1, 0, 5'd2, 8'h00, 0, 1, 0, 8'h42, "mid_pre");
    cycle(0, 1, 5'd2, 8'hFF, 1, 1, 0, 8'h00, "mid_rst_dout");
    cycle(1, 0, 5'd2, 8'h00, 0, 1, 0, 8'h00, "mid_rd2");
    cycle(1, 0, 5'd9, 8'h00, 0, 1, 0, 8'h00, "mid_rd9");

    // Randomised traffic checked against the reference model.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 31)), DW'($urandom_range(0, 255)),
            1'($urandom_range(0, 49) == 0), 1, 1, 8'h00, "rand");
    end

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: got %0d leftover entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
